// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: finds SOF/LEN/payload/XOR-checksum frames in a byte stream.
// It passes payload bytes through with a last marker, issues ok/err verdict pulses,
// and drops a stalled frame after an inter-byte timeout.
module uart_rx_frame_ctrl #(
   parameter int unsigned           DATA_WIDTH     = 8,
   parameter int unsigned           MAX_LEN        = 64,
   parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = 8'hA5,
   parameter int unsigned           TIMEOUT_CYCLES = 130208
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  frame_ok,
   output logic                  frame_err,
   output logic [1:0]            err_code,
   output logic [7:0]            frame_len,
   output logic [15:0]           err_cnt,
   output logic                  busy
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]         TMAX      = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;

   state_t                state, next_state;
   logic [DATA_WIDTH-1:0] len_reg, cnt, csum;
   logic [TW-1:0]         tcnt;
   logic                  accept, timeout, set_ok, set_err, len_good;
   logic [1:0]            code_nxt;

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state, handshake and pass-through decode; everything is held off during reset.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_data   = in_data;
      out_last   = 1'b0;
      set_ok     = 1'b0;
      set_err    = 1'b0;
      code_nxt   = err_code;
      len_good   = 1'b0;
      accept     = 1'b0;
      timeout    = (state != IDLE) && !in_valid && (tcnt == TMAX);
      if (!rst) begin
         case (state)
            IDLE:    in_ready = 1'b1;
            LEN:     in_ready = 1'b1;
            PAYLOAD: begin
               in_ready  = out_ready;
               out_valid = in_valid;
               out_last  = (cnt == DATA_WIDTH'(len_reg - 1'b1));
            end
            CSUM:    in_ready = 1'b1;
            default: in_ready = 1'b0;
         endcase
         accept = in_valid && in_ready;
         case (state)
            IDLE: begin
               if (accept && in_data == SOF_BYTE) next_state = LEN;
            end
            LEN: begin
               if (accept) begin
                  if (in_data == '0 || in_data > MAX_LEN_B) begin
                     set_err    = 1'b1;
                     code_nxt   = 2'd1;
                     next_state = IDLE;
                  end else begin
                     len_good   = 1'b1;
                     next_state = PAYLOAD;
                  end
               end else if (timeout) begin
                  set_err    = 1'b1;
                  code_nxt   = 2'd3;
                  next_state = IDLE;
               end
            end
            PAYLOAD: begin
               if (accept) begin
                  if (out_last) next_state = CSUM;
               end else if (timeout) begin
                  set_err    = 1'b1;
                  code_nxt   = 2'd3;
                  next_state = IDLE;
               end
            end
            CSUM: begin
               if (accept) begin
                  if (in_data == csum) begin
                     set_ok   = 1'b1;
                     code_nxt = 2'd0;
                  end else begin
                     set_err  = 1'b1;
                     code_nxt = 2'd2;
                  end
                  next_state = IDLE;
               end else if (timeout) begin
                  set_err    = 1'b1;
                  code_nxt   = 2'd3;
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Frame datapath: length, payload count, running checksum and inter-byte timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_reg <= '0;
         cnt     <= '0;
         csum    <= '0;
         tcnt    <= '0;
      end else begin
         // Timer only runs inside a frame and only while the source is idle.
         if (accept || state == IDLE || next_state == IDLE) tcnt <= '0;
         else if (!in_valid)                                 tcnt <= tcnt + TW'(1);
         if (len_good) begin
            len_reg <= in_data;
            cnt     <= '0;
            csum    <= in_data;
         end else if (accept && state == PAYLOAD) begin
            cnt  <= cnt + 1'b1;
            csum <= csum ^ in_data;
         end
      end
   end

   // Registered verdict pulses, sticky status and saturating error counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= '0;
         frame_len <= '0;
         err_cnt   <= '0;
      end else begin
         frame_ok  <= set_ok;
         frame_err <= set_err;
         if (set_ok || set_err)          err_code  <= code_nxt;
         if (len_good)                   frame_len <= in_data;
         if (set_err && err_cnt != '1)   err_cnt   <= err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed testbench for uart_rx_frame_ctrl with TIMEOUT_CYCLES=16.
module tb_uart_rx_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        frame_ok;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [7:0]  frame_len;
   logic [15:0] err_cnt;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   uart_rx_frame_ctrl #(
      .DATA_WIDTH(8),
      .MAX_LEN(64),
      .SOF_BYTE(8'hA5),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
      .frame_len(frame_len), .err_cnt(err_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one byte for exactly one cycle (out_ready assumed high), checking pass-through.
   task automatic send_byte(input logic [7:0] b, input bit pay, input bit last);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      chk("in_ready", in_ready, 1);
      chk("out_valid", out_valid, pay);
      if (pay) begin
         chk("out_data", out_data, b);
         chk("out_last", out_last, last);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Verdict is visible right after the deciding edge and gone one cycle later.
   task automatic verdict(input bit ok, input bit err, input logic [1:0] code, input logic [15:0] ecnt);
      chk("frame_ok", frame_ok, ok);
      chk("frame_err", frame_err, err);
      chk("err_code", err_code, code);
      chk("err_cnt", err_cnt, ecnt);
      chk("busy_after", busy, 0);
      @(posedge clk);
      #1;
      chk("ok_pulse_end", frame_ok, 0);
      chk("err_pulse_end", frame_err, 0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_frame_ok", frame_ok, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_frame_len", frame_len, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Good frame A5 03 11 22 33 03
      send_byte(8'hA5, 0, 0);
      chk("busy_in_frame", busy, 1);
      send_byte(8'h03, 0, 0);
      send_byte(8'h11, 1, 0);
      send_byte(8'h22, 1, 0);
      send_byte(8'h33, 1, 1);
      send_byte(8'h03, 0, 0);
      verdict(1, 0, 2'd0, 16'd0);
      chk("frame_len_3", frame_len, 8'd3);

      // Bad checksum A5 02 AA 55 00 (expected FD)
      send_byte(8'hA5, 0, 0);
      send_byte(8'h02, 0, 0);
      send_byte(8'hAA, 1, 0);
      send_byte(8'h55, 1, 1);
      send_byte(8'h00, 0, 0);
      verdict(0, 1, 2'd2, 16'd1);
      chk("frame_len_2", frame_len, 8'd2);

      // Illegal lengths 00 and 41
      send_byte(8'hA5, 0, 0);
      send_byte(8'h00, 0, 0);
      verdict(0, 1, 2'd1, 16'd2);
      send_byte(8'hA5, 0, 0);
      send_byte(8'h41, 0, 0);
      verdict(0, 1, 2'd1, 16'd3);
      chk("frame_len_kept", frame_len, 8'd2);

      // LEN==1: out_last on the only payload byte, csum 01^7E=7F
      send_byte(8'hA5, 0, 0);
      send_byte(8'h01, 0, 0);
      send_byte(8'h7E, 1, 1);
      send_byte(8'h7F, 0, 0);
      verdict(1, 0, 2'd0, 16'd3);

      // Junk then good frame A5 02 10 20 32
      send_byte(8'h00, 0, 0);
      send_byte(8'hFF, 0, 0);
      send_byte(8'h5A, 0, 0);
      chk("junk_no_err", frame_err, 0);
      chk("junk_no_ok", frame_ok, 0);
      chk("junk_idle", busy, 0);
      chk("junk_err_cnt", err_cnt, 16'd3);
      send_byte(8'hA5, 0, 0);
      send_byte(8'h02, 0, 0);
      send_byte(8'h10, 1, 0);
      send_byte(8'h20, 1, 1);
      send_byte(8'h32, 0, 0);
      verdict(1, 0, 2'd0, 16'd3);

      // Backpressure: 40 stalled cycles with in_valid high, no timeout
      send_byte(8'hA5, 0, 0);
      send_byte(8'h04, 0, 0);
      send_byte(8'h01, 1, 0);
      send_byte(8'h02, 1, 0);
      out_ready = 1'b0;
      in_data   = 8'h03;
      in_valid  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_no_err", frame_err, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_byte(8'h03, 1, 0);
      send_byte(8'h04, 1, 1);
      send_byte(8'h00, 0, 0);
      verdict(1, 0, 2'd0, 16'd3);
      chk("frame_len_4", frame_len, 8'd4);

      // Timeout: 16 idle cycles in PAYLOAD
      send_byte(8'hA5, 0, 0);
      send_byte(8'h03, 0, 0);
      send_byte(8'h55, 1, 0);
      repeat (15) @(posedge clk);
      #1;
      chk("pre_timeout_err", frame_err, 0);
      chk("pre_timeout_busy", busy, 1);
      @(posedge clk);
      #1;
      verdict(0, 1, 2'd3, 16'd4);
      chk("frame_len_after_to", frame_len, 8'd3);

      // Reset mid-frame after A5 04 11
      send_byte(8'hA5, 0, 0);
      send_byte(8'h04, 0, 0);
      send_byte(8'h11, 1, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_ok", frame_ok, 0);
      chk("mid_rst_err", frame_err, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err_cnt", err_cnt, 0);
      chk("mid_rst_err_code", err_code, 0);
      chk("mid_rst_frame_len", frame_len, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_no_pulse", frame_ok | frame_err, 0);
      send_byte(8'hA5, 0, 0);
      send_byte(8'h01, 0, 0);
      send_byte(8'h7E, 1, 1);
      send_byte(8'h7F, 0, 0);
      verdict(1, 0, 2'd0, 16'd0);
      chk("frame_len_1", frame_len, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
